// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the sync generator and renderers
package vga_timing_pkg;
  typedef logic [9:0] coord_t;
  localparam int H_DISP = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_DISP = 480, V_FP = 10, V_SYNC = 2, V_BP = 33;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC - 1;
  function automatic coord_t wrap_inc(input coord_t q, input coord_t last);
    return (q == last) ? '0 : q + 10'd1;
  endfunction
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: one-clk strobe every CLK_DIV clocks marking a pixel period
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] div_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) div_q <= '0;
    else div_q <= (div_q == LAST) ? '0 : div_q + W'(1);
  assign p_tick = div_q == LAST;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel counters, syncs and visible-area flag, all registered or decoded from registers
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP = vga_timing_pkg::H_DISP,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_DISP = vga_timing_pkg::V_DISP,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);
  import vga_timing_pkg::*;
  localparam coord_t H_LAST = coord_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = coord_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS = coord_t'(H_DISP);
  localparam coord_t V_VIS = coord_t'(V_DISP);
  localparam coord_t HS_START = coord_t'(H_DISP + H_FP);
  localparam coord_t HS_END = coord_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_DISP + V_FP);
  localparam coord_t VS_END = coord_t'(V_DISP + V_FP + V_SYNC - 1);
  coord_t h_q, v_q, h_d, v_d;
  logic h_end;
  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .p_tick(p_tick)
  );
  always_comb begin
    h_end = p_tick && (h_q == H_LAST);
    h_d = p_tick ? wrap_inc(h_q, H_LAST) : h_q;
    v_d = h_end ? wrap_inc(v_q, V_LAST) : v_q;
  end
  // syncs decode the next-state counters so they change on the same edge as pixel_x/pixel_y
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      hsync <= !(h_d >= HS_START && h_d <= HS_END);
      vsync <= !(v_d >= VS_START && v_d <= VS_END);
    end
  assign pixel_x = h_q;
  assign pixel_y = v_q;
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_tick = h_end && (v_q == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized checks of three vga_sync_gen instances against a closed-form timing model
module tb_vga_sync_gen;
  typedef struct packed {
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic p0, von0, hs0, vs0, ft0, p1, von1, hs1, vs1, ft1, p2, von2, hs2, vs2, ft2;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  exp_t o0, o1, o2;
  int k0 = 0, k1 = 0, k2 = 0;
  int checks = 0, errors = 0;

  vga_sync_gen d0 (.clk(clk), .reset(rst0), .p_tick(p0), .pixel_x(x0), .pixel_y(y0),
    .video_on(von0), .hsync(hs0), .vsync(vs0), .frame_tick(ft0));
  vga_sync_gen #(.CLK_DIV(2)) d1 (.clk(clk), .reset(rst1), .p_tick(p1), .pixel_x(x1), .pixel_y(y1),
    .video_on(von1), .hsync(hs1), .vsync(vs1), .frame_tick(ft1));
  vga_sync_gen #(.CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) d2 (.clk(clk), .reset(rst2), .p_tick(p2),
    .pixel_x(x2), .pixel_y(y2), .video_on(von2), .hsync(hs2), .vsync(vs2), .frame_tick(ft2));

  assign o0 = {p0, x0, y0, von0, hs0, vs0, ft0};
  assign o1 = {p1, x1, y1, von1, hs1, vs1, ft1};
  assign o2 = {p2, x2, y2, von2, hs2, vs2, ft2};

  // clocks elapsed since each DUT's reset was released
  always @(posedge clk or posedge rst0) k0 <= rst0 ? 0 : k0 + 1;
  always @(posedge clk or posedge rst1) k1 <= rst1 ? 0 : k1 + 1;
  always @(posedge clk or posedge rst2) k2 <= rst2 ? 0 : k2 + 1;

  // position after k clocks is simply pixel number k/d laid out on an ht x vt raster
  function automatic exp_t model(int k, int d, int hd, int hf, int hsn, int hb,
                                 int vd, int vf, int vsn, int vb);
    int ht = hd + hf + hsn + hb;
    int vt = vd + vf + vsn + vb;
    int pix = k / d;
    int h = pix % ht;
    int v = (pix / ht) % vt;
    exp_t e;
    e.p = (k % d) == d - 1;
    e.x = 10'(h);
    e.y = 10'(v);
    e.von = h < hd && v < vd;
    e.hs = !(h >= hd + hf && h < hd + hf + hsn);
    e.vs = !(v >= vd + vf && v < vd + vf + vsn);
    e.ft = e.p && h == ht - 1 && v == vt - 1;
    return e;
  endfunction

  function automatic exp_t m0(int k); return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33); endfunction
  function automatic exp_t m1(int k); return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33); endfunction
  function automatic exp_t m2(int k); return model(k, 2, 8, 2, 3, 2, 4, 1, 2, 1); endfunction

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (hs0 !== 1'b1) begin errors++; $display("FAIL reset_hsync got=%b exp=1", hs0); end
    if (vs0 !== 1'b1) begin errors++; $display("FAIL reset_vsync got=%b exp=1", vs0); end
    if (x0 !== 10'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x0); end
    if (y0 !== 10'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", y0); end
    if (von0 !== 1'b1) begin errors++; $display("FAIL reset_video_on got=%b exp=1", von0); end
    if (p0 !== 1'b0) begin errors++; $display("FAIL reset_p_tick got=%b exp=0", p0); end
    if (ft0 !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", ft0); end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (p0 !== 1'b0) begin errors++; $display("FAIL early_p_tick got=%b exp=0", p0); end
    end
    @(negedge clk);
    checks += 2;
    if (p0 !== 1'b1) begin errors++; $display("FAIL first_p_tick got=%b exp=1", p0); end
    if (x0 !== 10'd0) begin errors++; $display("FAIL pre_tick_x got=%0d exp=0", x0); end
    @(negedge clk);
    checks++;
    if (x0 !== 10'd1) begin errors++; $display("FAIL post_tick_x got=%0d exp=1", x0); end
  endtask

  task automatic test_line();
    int hs_low = 0, von_low = 0, wraps = 0, hs_start = -1;
    logic prev_hs = hs0;
    logic [9:0] prev_x = x0;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      checks++;
      if (o0 !== m0(k0)) begin errors++; $display("FAIL line_cmp k=%0d got=%h exp=%h", k0, o0, m0(k0)); end
      if (!hs0) hs_low++;
      if (!von0) von_low++;
      if (prev_hs && !hs0) hs_start = x0;
      if (prev_x == 10'd799 && x0 == 10'd0) wraps++;
      prev_hs = hs0;
      prev_x = x0;
    end
    checks += 4;
    if (hs_low != 384) begin errors++; $display("FAIL hsync_low_clocks got=%0d exp=384", hs_low); end
    if (von_low != 640) begin errors++; $display("FAIL video_off_clocks got=%0d exp=640", von_low); end
    if (hs_start != 656) begin errors++; $display("FAIL hsync_start_x got=%0d exp=656", hs_start); end
    if (wraps != 1) begin errors++; $display("FAIL line_wraps got=%0d exp=1", wraps); end
  endtask

  task automatic test_clkdiv2();
    int hs_low = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      checks++;
      if (o1 !== m1(k1)) begin errors++; $display("FAIL div2_cmp k=%0d got=%h exp=%h", k1, o1, m1(k1)); end
      if (!hs1) hs_low++;
    end
    checks++;
    if (hs_low != 192) begin errors++; $display("FAIL div2_hsync_low got=%0d exp=192", hs_low); end
  endtask

  task automatic test_frame();
    int ft_cnt = 0, last_ft = -1, vs_low = 0, vis_late = 0;
    logic prev_ft = 1'b0;
    for (int i = 0; i < 720; i++) begin
      @(negedge clk);
      checks++;
      if (o2 !== m2(k2)) begin errors++; $display("FAIL frame_cmp k=%0d got=%h exp=%h", k2, o2, m2(k2)); end
      if (prev_ft) begin
        checks++;
        if ({x2, y2} !== 20'd0) begin errors++; $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", x2, y2); end
      end
      if (ft2) begin
        if (last_ft >= 0) begin
          checks++;
          if (k2 - last_ft != 240) begin errors++; $display("FAIL frame_period got=%0d exp=240", k2 - last_ft); end
        end
        last_ft = k2;
        ft_cnt++;
      end
      if (!vs2) vs_low++;
      if (von2 && y2 >= 10'd4) vis_late++;
      prev_ft = ft2;
    end
    checks += 3;
    if (ft_cnt != 3) begin errors++; $display("FAIL frame_ticks got=%0d exp=3", ft_cnt); end
    if (vs_low != 180) begin errors++; $display("FAIL vsync_low_clocks got=%0d exp=180", vs_low); end
    if (vis_late != 0) begin errors++; $display("FAIL video_on_blank_lines got=%0d exp=0", vis_late); end
  endtask

  task automatic test_mid_reset();
    repeat ($urandom_range(50, 2000)) @(negedge clk);
    repeat ($urandom_range(100, 700)) @(negedge clk);
    #3;
    rst0 = 1'b1;
    rst2 = 1'b1;
    #1;
    checks += 2;
    if (o0 !== m0(0)) begin errors++; $display("FAIL async_reset_d0 got=%h exp=%h", o0, m0(0)); end
    if (o2 !== m2(0)) begin errors++; $display("FAIL async_reset_d2 got=%h exp=%h", o2, m2(0)); end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    rst0 = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks += 2;
      if (o0 !== m0(k0)) begin errors++; $display("FAIL restart_d0 k=%0d got=%h exp=%h", k0, o0, m0(k0)); end
      if (o2 !== m2(k2)) begin errors++; $display("FAIL restart_d2 k=%0d got=%h exp=%h", k2, o2, m2(k2)); end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_clkdiv2();
    test_frame();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
